line_fill_responder: RTL and testbench
======================================

LINE_FILL_RESPONDER -- requirements
Module: line_fill_responder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles per memory beat without MEM_ACK; 0 disables the timeout.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: CLK in 1, rising-edge clock for all state; nRESET in 1, asynchronous active-low reset.
REQ-003 SHALL have the following ports, each as name, direction, width, meaning:
- REQ_VALID in 1: cache line request valid.
- REQ_READY out 1: responder can accept a request.
- REQ_WRITE in 1: 1 = line writeback, 0 = line fill.
- REQ_ADDR in 28: line address (byte address bits 31:4).
- REQ_WDATA in 128: writeback line data.
- RSP_VALID out 1: response valid.
- RSP_READY in 1: cache accepts response.
- RSP_WRITE out 1: echo of REQ_WRITE for this response.
- RSP_ERR out 1: a beat timed out.
- RSP_RDATA out 128: fill line data.
- MEM_CS out 1: memory access request.
- MEM_WE out 1: memory write.
- MEM_ADDR out 30: memory word address.
- MEM_WDATA out 32: memory write word.
- MEM_RDATA in 32: memory read word.
- MEM_ACK in 1: beat complete.

Function
REQ-004 SHALL implement FSM states IDLE, ACCESS, RESPOND; REQ_READY=1 only in IDLE.
REQ-005 IDLE: REQ_VALID&REQ_READY at a rising edge SHALL capture REQ_WRITE/REQ_ADDR/REQ_WDATA, clear beat counter, timeout counter and RSP_ERR, clear RSP_RDATA to 0 when REQ_WRITE=0, and enter ACCESS.
REQ-006 ACCESS: MEM_CS=1; MEM_WE=captured write flag; MEM_ADDR={line_addr, beat[1:0]}; MEM_WDATA=line word[beat] (bits 32*beat+31:32*beat).
REQ-007 Beats SHALL be issued in order 0,1,2,3; MEM_CS stays high continuously across beats; address/data stable until MEM_ACK.
REQ-008 MEM_ACK sampled high in ACCESS SHALL complete the current beat (ACK may arrive in the first cycle of the beat, i.e. zero wait states); a fill stores MEM_RDATA into RSP_RDATA word[beat].
REQ-009 On the 4th beat's ACK, SHALL enter RESPOND; otherwise increment beat, reset timeout counter.
REQ-010 MEM_ACK while MEM_CS=0 SHALL be ignored.
REQ-011 Timeout counter (8 bits) SHALL count ACCESS cycles without ACK within a beat. When TIMEOUT!=0 and the count reaches TIMEOUT without ACK, the block SHALL set RSP_ERR=1 and enter RESPOND. Words not yet received stay 0.
REQ-012 RESPOND: RSP_VALID=1, MEM_CS=0. RSP_RDATA, RSP_WRITE and RSP_ERR are held stable while RSP_READY=0. RSP_VALID&RSP_READY at an edge SHALL return to IDLE.
REQ-013 Write responses SHALL carry RSP_WRITE=1; RSP_RDATA is then unspecified-but-stable (holds the previous value).
REQ-014 Latency with zero-wait memory: accept at edge 0, MEM_CS high cycles 1-4, RSP_VALID cycle 5. Minimum request-to-request spacing is 6 cycles.
REQ-015 A new request SHALL NOT be accepted in the cycle the response handshakes (REQ_READY=0 in RESPOND).

Reset
REQ-016 nRESET low SHALL immediately, asynchronously, force IDLE and set every output and internal register to 0, except REQ_READY, which becomes 1 after release.
REQ-017 Reset mid-ACCESS or mid-RESPOND SHALL drop MEM_CS and RSP_VALID in the same cycle; the in-flight request is discarded with no response.

Verification
REQ-018 Fill, zero-wait memory returning 0x11111111, 0x22222222, 0x33333333, 0x44444444 for addr 0xABCDE10 -> MEM_ADDR 0x2AF37840..43, RSP_VALID cycle 5, RSP_RDATA=0x44444444_33333333_22222222_11111111, RSP_ERR=0.
REQ-019 Writeback of 0xDEADBEEF_CAFEF00D_01234567_89ABCDEF with 2 wait states per beat -> MEM_WE=1, words written LSW first, RSP_VALID at cycle 13 with RSP_WRITE=1.
REQ-020 TIMEOUT=4, memory ACKs beat 0 (0x55AA55AA) then never -> RSP_ERR=1 after 4 idle cycles on beat 1, RSP_RDATA=0x0..0_55AA55AA.
REQ-021 RSP_READY held low 10 cycles -> RSP_VALID and data stable throughout, REQ_READY=0, then return to IDLE.
REQ-022 nRESET asserted during beat 2 -> MEM_CS=0 immediately, no RSP_VALID, next request completes normally.
REQ-023 Spurious MEM_ACK pulses in IDLE/RESPOND -> no state change, no data capture.

Source files
------------

// File: rtl/line_fill_responder.sv
// Cache line fill/writeback responder: splits one 128-bit line transfer into four
// 32-bit memory beats and returns a single response with data and timeout status.
`timescale 1ns/1ps

module line_fill_responder #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         CLK,
    input  logic         nRESET,

    input  logic         REQ_VALID,
    output logic         REQ_READY,
    input  logic         REQ_WRITE,
    input  logic [27:0]  REQ_ADDR,
    input  logic [127:0] REQ_WDATA,

    output logic         RSP_VALID,
    input  logic         RSP_READY,
    output logic         RSP_WRITE,
    output logic         RSP_ERR,
    output logic [127:0] RSP_RDATA,

    output logic         MEM_CS,
    output logic         MEM_WE,
    output logic [29:0]  MEM_ADDR,
    output logic [31:0]  MEM_WDATA,
    input  logic [31:0]  MEM_RDATA,
    input  logic         MEM_ACK
);

    // state   | meaning
    // IDLE    | waiting for a line request, REQ_READY high
    // ACCESS  | issuing beats 0..3 to memory, MEM_CS high
    // RESPOND | holding the response until RSP_READY
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam bit         TMO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TMO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t         state_q;
    logic           rdy_q;
    logic           cs_q;
    logic           rsp_valid_q;
    logic           wr_q;
    logic [27:0]    addr_q;
    logic [127:0]   wdata_q;
    logic [1:0]     beat_q;
    logic [7:0]     tmo_q;
    logic           err_q;
    logic [127:0]   rdata_q;

    logic [6:0]     word_lsb_d;
    logic           tmo_hit_d;
    logic           last_beat_d;

    assign word_lsb_d  = {beat_q, 5'd0};
    assign tmo_hit_d   = TMO_EN && (tmo_q == TMO_LAST);
    assign last_beat_d = (beat_q == 2'd3);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b0;
            cs_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            beat_q      <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rdy_q <= 1'b1;
                    // rdy_q is low for the first cycle after reset, so no accept then
                    if (rdy_q && REQ_VALID) begin
                        wr_q    <= REQ_WRITE;
                        addr_q  <= REQ_ADDR;
                        wdata_q <= REQ_WDATA;
                        beat_q  <= '0;
                        tmo_q   <= '0;
                        err_q   <= 1'b0;
                        if (!REQ_WRITE) begin
                            rdata_q <= '0;
                        end
                        rdy_q   <= 1'b0;
                        cs_q    <= 1'b1;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (MEM_ACK) begin
                        if (!wr_q) begin
                            rdata_q[word_lsb_d +: 32] <= MEM_RDATA;
                        end
                        tmo_q <= '0;
                        if (last_beat_d) begin
                            cs_q        <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESPOND;
                        end else begin
                            beat_q <= beat_q + 2'd1;
                        end
                    end else if (tmo_hit_d) begin
                        err_q       <= 1'b1;
                        cs_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESPOND;
                    end else if (tmo_q != 8'hFF) begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                RESPOND: begin
                    if (RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        rdy_q       <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rdy_q       <= 1'b0;
                    cs_q        <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign REQ_READY = rdy_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_WRITE = wr_q;
    assign RSP_ERR   = err_q;
    assign RSP_RDATA = rdata_q;
    assign MEM_CS    = cs_q;
    assign MEM_WE    = cs_q & wr_q;
    assign MEM_ADDR  = {addr_q, beat_q};
    assign MEM_WDATA = wdata_q[word_lsb_d +: 32];

endmodule

// File: tb/tb_line_fill_responder.sv
// Bench for line_fill_responder: vector table of line transfers against a reactive
// memory model, response scoreboard, plus reset and spurious-ACK sequences.
`timescale 1ns/1ps

module tb_line_fill_responder;

    localparam int TMO = 4;

    logic         CLK = 1'b0;
    logic         nRESET;
    logic         REQ_VALID, REQ_READY, REQ_WRITE;
    logic [27:0]  REQ_ADDR;
    logic [127:0] REQ_WDATA;
    logic         RSP_VALID, RSP_READY, RSP_WRITE, RSP_ERR;
    logic [127:0] RSP_RDATA;
    logic         MEM_CS, MEM_WE;
    logic [29:0]  MEM_ADDR;
    logic [31:0]  MEM_WDATA, MEM_RDATA;
    logic         MEM_ACK;

    always #5 CLK = ~CLK;

    line_fill_responder #(.TIMEOUT(TMO)) dut (
        .CLK(CLK), .nRESET(nRESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WRITE(RSP_WRITE),
        .RSP_ERR(RSP_ERR), .RSP_RDATA(RSP_RDATA),
        .MEM_CS(MEM_CS), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK)
    );

    typedef struct {
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] data;       // write data, or the four words memory returns
        int           waits;      // wait cycles before each ACK
        int           ack_beats;  // beats memory will ever acknowledge
        int           rdy_delay;  // cycles RSP_READY is held low
        bit           spur;       // spurious ACK pulses while MEM_CS is low
        logic [127:0] exp_rdata;  // fills only; writes expect the previous line
        logic         exp_err;
        int           exp_cyc;    // RSP_VALID cycle counted from the accept edge
        int           exp_beats;
    } vec_t;

    typedef struct {
        logic         wr;
        logic         err;
        logic [127:0] rdata;
    } rsp_t;

    rsp_t         sb[$];
    logic [29:0]  log_addr[$];
    logic         log_we[$];
    logic [31:0]  log_wd[$];

    int           mem_waits = 0;
    int           mem_ack_beats = 0;
    int           beats_acked = 0;
    int           wait_cnt = 0;
    int           mem_idx = 0;
    logic [127:0] mem_words = '0;
    bit           spurious = 1'b0;

    int           n_chk = 0;
    int           n_pass = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    logic [127:0] model_rdata = '0;
    vec_t         vecs[10];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Memory model: decides MEM_ACK on each falling edge for the next rising edge.
    initial begin
        MEM_ACK   = 1'b0;
        MEM_RDATA = '0;
        forever begin
            @(negedge CLK);
            if (MEM_CS === 1'b1) begin
                if (wait_cnt >= mem_waits && beats_acked < mem_ack_beats) begin
                    mem_idx   = int'(MEM_ADDR[1:0]);
                    MEM_ACK   = 1'b1;
                    MEM_RDATA = mem_words[mem_idx*32 +: 32];
                    log_addr.push_back(MEM_ADDR);
                    log_we.push_back(MEM_WE);
                    log_wd.push_back(MEM_WDATA);
                    beats_acked++;
                    wait_cnt = 0;
                end else begin
                    MEM_ACK   = 1'b0;
                    MEM_RDATA = $urandom;
                    wait_cnt++;
                end
            end else begin
                MEM_ACK   = spurious;
                MEM_RDATA = $urandom;
                wait_cnt  = 0;
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        rsp_t         e;
        int           n;
        bit           got;
        bit           stable;
        logic [127:0] hold;
        logic         hold_err, hold_wr;
        mem_waits     = v.waits;
        mem_ack_beats = v.ack_beats;
        beats_acked   = 0;
        mem_words     = v.wr ? 128'd0 : v.data;
        spurious      = v.spur;
        log_addr.delete();
        log_we.delete();
        log_wd.delete();
        n = 0;
        while (REQ_READY !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, ".req_ready"}, 128'(REQ_READY), 128'(1));
        REQ_VALID = 1'b1;
        REQ_WRITE = v.wr;
        REQ_ADDR  = v.addr;
        REQ_WDATA = v.wr ? v.data : {$urandom, $urandom, $urandom, $urandom};
        acc_cyc   = cyc;
        e.wr      = v.wr;
        e.err     = v.exp_err;
        e.rdata   = v.wr ? model_rdata : v.exp_rdata;
        if (!v.wr) model_rdata = v.exp_rdata;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        REQ_WDATA = {$urandom, $urandom, $urandom, $urandom};
        REQ_ADDR  = 28'(~v.addr);
        got = 1'b0;
        n = 0;
        while (!got && n < 400) begin
            @(negedge CLK);
            n++;
            if (RSP_VALID === 1'b1) got = 1'b1;
        end
        chk({tag, ".rsp_seen"}, 128'(got), 128'(1));
        if (!got) begin
            void'(sb.pop_front());
            spurious = 1'b0;
            return;
        end
        chk({tag, ".latency"}, 128'(n), 128'(v.exp_cyc));
        chk({tag, ".ready_in_rsp"}, 128'(REQ_READY), 128'(0));
        chk({tag, ".cs_in_rsp"}, 128'(MEM_CS), 128'(0));
        hold     = RSP_RDATA;
        hold_err = RSP_ERR;
        hold_wr  = RSP_WRITE;
        stable   = 1'b1;
        for (int i = 0; i < v.rdy_delay; i++) begin
            @(negedge CLK);
            if (RSP_VALID !== 1'b1 || RSP_RDATA !== hold || RSP_ERR !== hold_err ||
                RSP_WRITE !== hold_wr || REQ_READY !== 1'b0 || MEM_CS !== 1'b0)
                stable = 1'b0;
        end
        if (v.rdy_delay > 0) chk({tag, ".hold_stable"}, 128'(stable), 128'(1));
        RSP_READY = 1'b1;
        #1;
        e = sb.pop_front();
        chk({tag, ".rsp_write"}, 128'(RSP_WRITE), 128'(e.wr));
        chk({tag, ".rsp_err"}, 128'(RSP_ERR), 128'(e.err));
        chk({tag, ".rsp_rdata"}, RSP_RDATA, e.rdata);
        @(posedge CLK);
        #1;
        RSP_READY = 1'b0;
        @(negedge CLK);
        chk({tag, ".idle_valid"}, 128'(RSP_VALID), 128'(0));
        chk({tag, ".idle_ready"}, 128'(REQ_READY), 128'(1));
        chk({tag, ".beats"}, 128'(log_addr.size()), 128'(v.exp_beats));
        for (int i = 0; i < log_addr.size() && i < 4; i++) begin
            chk({tag, ".mem_addr"}, 128'(log_addr[i]), 128'({v.addr, 2'(i)}));
            chk({tag, ".mem_we"}, 128'(log_we[i]), 128'(v.wr));
            if (v.wr) chk({tag, ".mem_wdata"}, 128'(log_wd[i]), 128'(v.data[i*32 +: 32]));
        end
        spurious = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int  n;
        int  first_acc;
        bit  ok;
        nRESET    = 1'b0;
        REQ_VALID = 1'b0;
        REQ_WRITE = 1'b0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        RSP_READY = 1'b0;

        vecs[0] = '{1'b0, 28'hABCDE10, 128'h44444444_33333333_22222222_11111111, 0, 4, 0, 1'b0,
                    128'h44444444_33333333_22222222_11111111, 1'b0, 5, 4};
        vecs[1] = '{1'b0, 28'h0000010, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 0, 4, 0, 1'b0,
                    128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b0, 5, 4};
        vecs[2] = '{1'b1, 28'h1234567, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 2, 4, 0, 1'b0,
                    128'h0, 1'b0, 13, 4};
        vecs[3] = '{1'b0, 28'h0000001, 128'h99999999_99999999_99999999_55AA55AA, 0, 1, 0, 1'b0,
                    128'h00000000_00000000_00000000_55AA55AA, 1'b1, 6, 1};
        vecs[4] = '{1'b0, 28'hFFFFFFF, 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C, 0, 4, 10, 1'b1,
                    128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C, 1'b0, 5, 4};
        vecs[5] = '{1'b0, 28'h8000000, 128'h13579BDF_2468ACE0_FEDCBA98_76543210, 3, 4, 0, 1'b0,
                    128'h13579BDF_2468ACE0_FEDCBA98_76543210, 1'b0, 17, 4};
        vecs[6] = '{1'b0, 28'h5555555, 128'h77777777_66666666_55555555_44444444, 4, 4, 0, 1'b0,
                    128'h0, 1'b1, 5, 0};
        vecs[7] = '{1'b1, 28'h2222222, 128'h01020304_05060708_090A0B0C_0D0E0F10, 0, 2, 0, 1'b0,
                    128'h0, 1'b1, 7, 2};
        vecs[8] = '{1'b1, 28'h7777777, 128'hF0F0F0F0_0F0F0F0F_12345678_9ABCDEF0, 1, 4, 3, 1'b1,
                    128'h0, 1'b0, 9, 4};
        vecs[9] = '{1'b0, 28'h0C0FFEE, 128'h89ABCDEF_01234567_FEDCBA98_76543210, 0, 4, 0, 1'b0,
                    128'h89ABCDEF_01234567_FEDCBA98_76543210, 1'b0, 5, 4};

        repeat (3) @(negedge CLK);
        chk("rst.req_ready", 128'(REQ_READY), 128'(0));
        chk("rst.rsp_valid", 128'(RSP_VALID), 128'(0));
        chk("rst.mem_cs", 128'(MEM_CS), 128'(0));
        chk("rst.mem_bus", 128'({MEM_WE, MEM_ADDR, MEM_WDATA}), 128'(0));
        chk("rst.rsp_bus", 128'({RSP_WRITE, RSP_ERR}), 128'(0));
        chk("rst.rsp_rdata", RSP_RDATA, 128'(0));
        nRESET = 1'b1;
        @(negedge CLK);
        chk("rst.release_ready", 128'(REQ_READY), 128'(1));

        run_vec(vecs[0], "v0_fill");
        first_acc = acc_cyc;
        run_vec(vecs[1], "v1_fill");
        chk("spacing", 128'(acc_cyc - first_acc), 128'(6));
        for (int i = 2; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset during beat 2 of a fill: request dropped, no response.
        mem_waits = 1; mem_ack_beats = 4; beats_acked = 0;
        mem_words = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        log_addr.delete(); log_we.delete(); log_wd.delete();
        REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 28'h3333333;
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
        n = 0;
        while (log_addr.size() < 2 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        chk("mid_rst.beat2_cs", 128'(MEM_CS), 128'(1));
        chk("mid_rst.beat2_addr", 128'(MEM_ADDR), 128'({28'h3333333, 2'd2}));
        #2 nRESET = 1'b0;
        #1;
        chk("mid_rst.cs_drop", 128'(MEM_CS), 128'(0));
        chk("mid_rst.no_valid", 128'(RSP_VALID), 128'(0));
        chk("mid_rst.ready_low", 128'(REQ_READY), 128'(0));
        chk("mid_rst.regs_clear", {RSP_RDATA[127:31], MEM_ADDR, RSP_ERR}, 128'(0));
        model_rdata = '0;
        repeat (2) @(negedge CLK);
        nRESET = 1'b1;
        ok = 1'b1;
        repeat (8) begin
            @(negedge CLK);
            if (RSP_VALID !== 1'b0 || MEM_CS !== 1'b0) ok = 1'b0;
        end
        chk("mid_rst.no_response", 128'(ok), 128'(1));

        // Spurious ACK pulses while idle.
        spurious = 1'b1;
        ok = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            if (REQ_READY !== 1'b1 || MEM_CS !== 1'b0 || RSP_VALID !== 1'b0 ||
                RSP_RDATA !== model_rdata) ok = 1'b0;
        end
        spurious = 1'b0;
        chk("idle_spurious", 128'(ok), 128'(1));

        run_vec(vecs[9], "v9_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
